// File: rtl/branch_flag_generator.sv
// -----------------------------------------------------------------------------
// branch_flag_generator
//
// Purpose:
//   Multi-cycle comparator that produces branch flags for two 32-bit operands.
//   The operands are latched on start.
//   The comparator then scans them one DIGIT_BITS-wide digit per cycle,
//   starting at the most-significant digit.
//   It stops at the first digit that differs, or after the last digit.
//   The flags are registered and hold until the next decision.
//
// Parameters:
//   DIGIT_BITS  bits compared per scan cycle (1, 2, 4, 8, 16 or 32).
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   compare request; accepted in IDLE or DONE when flush is low
//   flush  in   abort; wins over start
//   opA    in   32-bit first operand (rs1)
//   opB    in   32-bit second operand (rs2)
//   busy   out  high while scanning
//   done   out  one-cycle pulse when the flags have just been updated
//   Eq     out  opA == opB
//   Gt     out  opA >  opB, signed
//   GtU    out  opA >  opB, unsigned
// -----------------------------------------------------------------------------
module branch_flag_generator #(
  parameter int DIGIT_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        busy,
  output logic        done,
  output logic        Eq,
  output logic        Gt,
  output logic        GtU
);

  localparam int NDIG = 32 / DIGIT_BITS;
  // A single-digit configuration still gets a 1-bit index, which stays at zero.
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic            eq_q, eq_d;
  logic            gt_q, gt_d;
  logic            gtu_q, gtu_d;

  // Split the latched operands into digits. Digit 0 is the least significant.
  logic [DIGIT_BITS-1:0] dig_a [NDIG];
  logic [DIGIT_BITS-1:0] dig_b [NDIG];

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign dig_a[gi] = opa_q[gi*DIGIT_BITS +: DIGIT_BITS];
      assign dig_b[gi] = opb_q[gi*DIGIT_BITS +: DIGIT_BITS];
    end
  endgenerate

  // Select the digit currently under inspection.
  // An explicit match loop is used so that the index width never has to equal
  // log2 of the array depth, including when there is only one digit.
  logic [DIGIT_BITS-1:0] cur_a, cur_b;

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IDXW'(i)) begin
        cur_a = dig_a[i];
        cur_b = dig_b[i];
      end
    end
  end

  logic digit_gtu;
  assign digit_gtu = (cur_a > cur_b);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    gtu_d   = gtu_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE always lasts one cycle.
        // From there, a new start can be accepted back-to-back.
        if (start && !flush) begin
          opa_d   = opA;
          opb_d   = opB;
          idx_d   = IDX_TOP;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        // A start request during the scan is ignored.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cur_a != cur_b) begin
          // The first differing digit decides the result.
          // When the sign bits differ, the signed order is the inverse of the
          // unsigned order.
          eq_d    = 1'b0;
          gtu_d   = digit_gtu;
          gt_d    = digit_gtu ^ (opa_q[31] ^ opb_q[31]);
          state_d = ST_DONE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDXW'(1);
        end else begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          gtu_d   = 1'b0;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      gtu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      gtu_q   <= gtu_d;
    end
  end

  // busy and done are decoded from the registered state.
  // They therefore follow reset immediately and can never be high together.
  assign busy = (state_q == ST_SCAN);
  assign done = (state_q == ST_DONE);
  assign Eq   = eq_q;
  assign Gt   = gt_q;
  assign GtU  = gtu_q;

endmodule
